cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_pkg.sv | 28 ++
 rtl/cdb_arbiter_wb_fifo.sv | 73 +++++++
 rtl/cdb_arbiter.sv | 83 ++++++++
 tb/tb_cdb_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared types and grant helper for the CDB arbiter
package cdb_arbiter_pkg;

  localparam int ROB_ID_WIDTH   = 4;
  localparam int REG_DATA_WIDTH = 32;

  typedef logic [ROB_ID_WIDTH-1:0]   rob_id_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

  typedef struct packed {
    rob_id_t   rob_id;
    reg_data_t reg_data;
  } cdb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } cdb_src_e;

  // A lone non-empty head always wins; rr_ptr only breaks ties.
  function automatic cdb_src_e rr_pick(input logic alu_has, input logic ld_has,
                                       input cdb_src_e rr_ptr);
    if (alu_has && ld_has) return rr_ptr;
    else if (ld_has)       return SRC_LD;
    else                   return SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_arbiter_wb_fifo.sv
// rtl/cdb_arbiter_wb_fifo.sv - per-source writeback FIFO holding results that lose arbitration
module cdb_arbiter_wb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ROB_ID_WIDTH + REG_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  always_comb begin
    // Ready ignores a same-cycle pop so a full FIFO never accepts.
    enq_ready = (count_q < CNT_W'(DEPTH)) & ~flush;
    empty     = (count_q == '0);
    head_data = mem_q[head_q];
    push      = enq_valid & enq_ready;
    pop       = deq & ~empty & ~flush;

    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = enq_data;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin sharing of the CDB broadcast bus between ALU and load writebacks
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_ID_W   = ROB_ID_WIDTH,
  parameter int DATA_W     = REG_DATA_WIDTH
) (
  input  logic                clk,
  input  logic                rst_aL,
  input  logic                flush,
  input  logic                alu_wb_valid,
  output logic                alu_wb_ready,
  input  logic [ROB_ID_W-1:0] alu_wb_rob_id,
  input  logic [DATA_W-1:0]   alu_wb_reg_data,
  input  logic                ld_wb_valid,
  output logic                ld_wb_ready,
  input  logic [ROB_ID_W-1:0] ld_wb_rob_id,
  input  logic [DATA_W-1:0]   ld_wb_reg_data,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_reg_data,
  output logic                cdb_src
);

  localparam int ENTRY_W = ROB_ID_W + DATA_W;

  logic [ENTRY_W-1:0] alu_head, ld_head, sel_head;
  logic               alu_empty, ld_empty, alu_deq, ld_deq;
  cdb_src_e           grant, rr_ptr_q, rr_ptr_d;

  cdb_arbiter_wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_alu_fifo (
    .clk       (clk),
    .rst_aL    (rst_aL),
    .flush     (flush),
    .enq_valid (alu_wb_valid),
    .enq_ready (alu_wb_ready),
    .enq_data  ({alu_wb_rob_id, alu_wb_reg_data}),
    .deq       (alu_deq),
    .empty     (alu_empty),
    .head_data (alu_head)
  );

  cdb_arbiter_wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_ld_fifo (
    .clk       (clk),
    .rst_aL    (rst_aL),
    .flush     (flush),
    .enq_valid (ld_wb_valid),
    .enq_ready (ld_wb_ready),
    .enq_data  ({ld_wb_rob_id, ld_wb_reg_data}),
    .deq       (ld_deq),
    .empty     (ld_empty),
    .head_data (ld_head)
  );

  always_comb begin
    grant     = rr_pick(~alu_empty, ~ld_empty, rr_ptr_q);
    cdb_valid = (~alu_empty | ~ld_empty) & ~flush;
    alu_deq   = cdb_valid & (grant == SRC_ALU);
    ld_deq    = cdb_valid & (grant == SRC_LD);
    sel_head  = (grant == SRC_LD) ? ld_head : alu_head;

    rr_ptr_d = rr_ptr_q;
    if (flush)          rr_ptr_d = SRC_ALU;
    else if (cdb_valid) rr_ptr_d = (grant == SRC_ALU) ? SRC_LD : SRC_ALU;

    // Idle bus is forced to zero so consumers never see stale heads.
    cdb_rob_id   = '0;
    cdb_reg_data = '0;
    cdb_src      = 1'b0;
    if (cdb_valid) begin
      cdb_rob_id   = sel_head[ENTRY_W-1:DATA_W];
      cdb_reg_data = sel_head[DATA_W-1:0];
      cdb_src      = (grant == SRC_LD);
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) rr_ptr_q <= SRC_ALU;
    else         rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed table-driven bench for cdb_arbiter
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_aL = 1'b0;
  logic        flush = 1'b0;
  logic        alu_wb_valid = 1'b0, ld_wb_valid = 1'b0;
  logic        alu_wb_ready, ld_wb_ready;
  logic [3:0]  alu_wb_rob_id = '0, ld_wb_rob_id = '0;
  logic [31:0] alu_wb_reg_data = '0, ld_wb_reg_data = '0;
  logic        cdb_valid, cdb_src;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_reg_data;

  int checks = 0;
  int failures = 0;

  cdb_arbiter #(.FIFO_DEPTH(2), .ROB_ID_W(4), .DATA_W(32)) dut (
    .clk             (clk),
    .rst_aL          (rst_aL),
    .flush           (flush),
    .alu_wb_valid    (alu_wb_valid),
    .alu_wb_ready    (alu_wb_ready),
    .alu_wb_rob_id   (alu_wb_rob_id),
    .alu_wb_reg_data (alu_wb_reg_data),
    .ld_wb_valid     (ld_wb_valid),
    .ld_wb_ready     (ld_wb_ready),
    .ld_wb_rob_id    (ld_wb_rob_id),
    .ld_wb_reg_data  (ld_wb_reg_data),
    .cdb_valid       (cdb_valid),
    .cdb_rob_id      (cdb_rob_id),
    .cdb_reg_data    (cdb_reg_data),
    .cdb_src         (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [3:0]  aid;
    logic [31:0] adat;
    logic        lv;
    logic [3:0]  lid;
    logic [31:0] ldat;
    logic        fl;
    logic        e_ardy;
    logic        e_lrdy;
    logic        e_v;
    logic [3:0]  e_id;
    logic [31:0] e_dat;
    logic        e_src;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic av, input logic [3:0] aid, input logic [31:0] adat,
                     input logic lv, input logic [3:0] lid, input logic [31:0] ldat,
                     input logic fl, input logic e_ardy, input logic e_lrdy,
                     input logic e_v, input logic [3:0] e_id, input logic [31:0] e_dat,
                     input logic e_src);
    vec_t v;
    v.av = av; v.aid = aid; v.adat = adat;
    v.lv = lv; v.lid = lid; v.ldat = ldat;
    v.fl = fl; v.e_ardy = e_ardy; v.e_lrdy = e_lrdy;
    v.e_v = e_v; v.e_id = e_id; v.e_dat = e_dat; v.e_src = e_src;
    vecs.push_back(v);
  endtask

  task automatic idle_expect(input logic ardy, input logic lrdy, input logic v,
                             input logic [3:0] id, input logic [31:0] dat, input logic src);
    add(0, 0, 0, 0, 0, 0, 0, ardy, lrdy, v, id, dat, src);
  endtask

  initial begin
    // single source and simultaneous arrival (flush first to restore rr_ptr=ALU)
    idle_expect(1, 1, 0, 0, 0, 0);
    add(1, 3, 'h11, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    idle_expect(1, 1, 1, 3, 'h11, 0);
    idle_expect(1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 'hA1, 1, 2, 'hB2, 0, 1, 1, 0, 0, 0, 0);
    idle_expect(1, 1, 1, 1, 'hA1, 0);
    idle_expect(1, 1, 1, 2, 'hB2, 1);
    idle_expect(1, 1, 0, 0, 0, 0);
    // sustained contention: sources hold an item until it is accepted
    add(1, 0, 'hA0, 1, 8,  'hB0, 0, 1, 1, 0, 0,  0,     0);
    add(1, 1, 'hA1, 1, 9,  'hB1, 0, 1, 1, 1, 0,  'hA0, 0);
    add(1, 2, 'hA2, 1, 10, 'hB2, 0, 1, 0, 1, 8,  'hB0, 1);
    add(1, 3, 'hA3, 1, 10, 'hB2, 0, 0, 1, 1, 1,  'hA1, 0);
    add(1, 3, 'hA3, 1, 11, 'hB3, 0, 1, 0, 1, 9,  'hB1, 1);
    add(1, 4, 'hA4, 1, 11, 'hB3, 0, 0, 1, 1, 2,  'hA2, 0);
    add(1, 4, 'hA4, 1, 12, 'hB4, 0, 1, 0, 1, 10, 'hB2, 1);
    add(1, 5, 'hA5, 1, 12, 'hB4, 0, 0, 1, 1, 3,  'hA3, 0);
    idle_expect(1, 0, 1, 11, 'hB3, 1);
    idle_expect(1, 1, 1, 4,  'hA4, 0);
    idle_expect(1, 1, 1, 12, 'hB4, 1);
    idle_expect(1, 1, 0, 0, 0, 0);
    // full load FIFO: ready stays low in its pop cycle
    add(1, 13, 'hD0, 1, 12, 'hC0, 0, 1, 1, 0, 0,  0,     0);
    add(0, 0,  0,    1, 14, 'hE0, 0, 1, 1, 1, 13, 'hD0, 0);
    add(0, 0,  0,    1, 15, 'hF0, 0, 1, 0, 1, 12, 'hC0, 1);
    add(0, 0,  0,    1, 15, 'hF0, 0, 1, 1, 1, 14, 'hE0, 1);
    idle_expect(1, 1, 1, 15, 'hF0, 1);
    idle_expect(1, 1, 0, 0, 0, 0);
    // flush with two ALU and one load entry queued
    add(1, 1, 'h51, 1, 2, 'h62, 0, 1, 1, 0, 0, 0,     0);
    add(1, 3, 'h53, 0, 0, 0,    0, 1, 1, 1, 1, 'h51, 0);
    add(1, 4, 'h54, 1, 6, 'h66, 0, 1, 1, 1, 2, 'h62, 1);
    add(1, 7, 'h77, 1, 8, 'h88, 1, 0, 0, 0, 0, 0,     0);
    add(1, 5, 'h55, 1, 9, 'h99, 0, 1, 1, 0, 0, 0,     0);
    idle_expect(1, 1, 1, 5, 'h55, 0);
    idle_expect(1, 1, 1, 9, 'h99, 1);
    idle_expect(1, 1, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    rst_aL = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      alu_wb_valid = vecs[i].av;  alu_wb_rob_id = vecs[i].aid;  alu_wb_reg_data = vecs[i].adat;
      ld_wb_valid  = vecs[i].lv;  ld_wb_rob_id  = vecs[i].lid;  ld_wb_reg_data  = vecs[i].ldat;
      flush        = vecs[i].fl;
      #1;
      check($sformatf("v%0d_alu_ready", i), 32'(alu_wb_ready), 32'(vecs[i].e_ardy));
      check($sformatf("v%0d_ld_ready", i),  32'(ld_wb_ready),  32'(vecs[i].e_lrdy));
      check($sformatf("v%0d_cdb_valid", i), 32'(cdb_valid),    32'(vecs[i].e_v));
      check($sformatf("v%0d_cdb_rob_id", i), 32'(cdb_rob_id),  32'(vecs[i].e_id));
      check($sformatf("v%0d_cdb_data", i),  cdb_reg_data,      vecs[i].e_dat);
      check($sformatf("v%0d_cdb_src", i),   32'(cdb_src),      32'(vecs[i].e_src));
    end

    // asynchronous reset with entries queued
    @(negedge clk);
    alu_wb_valid = 1'b1; alu_wb_rob_id = 4'd6; alu_wb_reg_data = 'h66;
    ld_wb_valid  = 1'b1; ld_wb_rob_id  = 4'd7; ld_wb_reg_data  = 'h77;
    flush = 1'b0;
    @(negedge clk);
    alu_wb_valid = 1'b0; ld_wb_valid = 1'b0;
    #1;
    check("rst_pre_valid", 32'(cdb_valid), 32'd1);
    check("rst_pre_rob_id", 32'(cdb_rob_id), 32'd6);
    #1 rst_aL = 1'b0;
    #1;
    check("rst_async_valid", 32'(cdb_valid), 32'd0);
    check("rst_async_rob_id", 32'(cdb_rob_id), 32'd0);
    check("rst_async_alu_ready", 32'(alu_wb_ready), 32'd1);
    check("rst_async_ld_ready", 32'(ld_wb_ready), 32'd1);
    @(negedge clk);
    rst_aL = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_post%0d_valid", k), 32'(cdb_valid), 32'd0);
      check($sformatf("rst_post%0d_rob_id", k), 32'(cdb_rob_id), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
